ipf_lcu_feeder: RTL and testbench

- Upstream stage of the image processing filter. Reads a 128x128 8-bit image from the image ROM in LCU order, with pixels in raster order inside each LCU.
- Reads one 24-bit parameter word per LCU from the parameter ROM.
- Drives the filter's in_en/din stream and the per-LCU side-band (ipf_type, band_pos, wo_class, offset, lcu_x, lcu_y, lcu_size), honouring the filter's busy stall without losing or duplicating pixels.

---
 rtl/ipf_lcu_feeder.sv | 230 +++++++++++++++++++++++
 tb/tb_ipf_lcu_feeder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ipf_lcu_feeder.sv
// ipf_lcu_feeder: upstream stage of the image processing filter.
// Walks a 128x128 8-bit image in LCU order (raster order inside each LCU).
// It fetches one parameter word per LCU and streams pixels to the filter as
// in_en/din, together with the per-LCU side-band. It honours the filter's
// busy stall through a one-deep in-flight slot plus a one-entry skid register.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             one-cycle frame start (ignored unless idle)
//   cfg_lcu_size      0=16, 1=32, 2/3=64, sampled on start
//   img_rd/img_addr   image ROM read, address {y[6:0], x[6:0]}
//   img_q             image ROM data, valid one cycle after img_rd
//   prm_rd/prm_addr   parameter ROM read, address = LCU index
//   prm_q             {type, band_pos, wo_class, offset}, one cycle latency
//   busy              filter stall request
//   in_en/din         pixel stream to the filter
//   ipf_*, lcu_x/y    side-band of the LCU currently on din
//   lcu_size          frame LCU size code
//   done              one-cycle pulse after the last pixel of the frame
module ipf_lcu_feeder #(
  parameter int IMG_W  = 128,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        cfg_lcu_size,
  output logic              img_rd,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [7:0]        img_q,
  output logic              prm_rd,
  output logic [5:0]        prm_addr,
  input  logic [23:0]       prm_q,
  input  logic              busy,
  output logic              in_en,
  output logic [7:0]        din,
  output logic [1:0]        ipf_type,
  output logic [4:0]        ipf_band_pos,
  output logic              ipf_wo_class,
  output logic [15:0]       ipf_offset,
  output logic [2:0]        lcu_x,
  output logic [2:0]        lcu_y,
  output logic [1:0]        lcu_size,
  output logic              done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRM    = 3'd1;
  localparam logic [2:0] S_PRMW   = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [1:0]  size_q;                 // only 0..2 are ever stored
  logic [2:0]  fx_q, fy_q;             // LCU being fetched
  logic [5:0]  px_q, py_q;             // pixel inside the fetched LCU
  logic [23:0] stg_prm_q;
  logic [2:0]  stg_x_q, stg_y_q;
  logic        rd_vld_q, rd_first_q;   // in-flight ROM word
  logic        skid_vld_q, skid_first_q;
  logic [7:0]  skid_q;
  logic        in_en_q, done_q, done_d;
  logic [7:0]  din_q;
  logic [23:0] prm_out_q;
  logic [2:0]  lx_out_q, ly_out_q;

  logic [5:0]  px_max;
  logic [2:0]  lcu_max;
  logic [6:0]  ax, ay;
  logic        px_last, py_last, fx_last, fy_last, empty;
  logic        out_vld, out_first;
  logic [7:0]  out_pix;

  // Size-dependent limits and address composition: the LCU index supplies the
  // high bits of x/y and the in-LCU offset the low bits.
  always_comb begin
    px_max   = 6'd63;
    lcu_max  = 3'd1;
    ax       = {fx_q[0], px_q};
    ay       = {fy_q[0], py_q};
    prm_addr = {4'd0, fy_q[0], fx_q[0]};
    case (size_q)
      2'd0: begin
        px_max   = 6'd15;
        lcu_max  = 3'd7;
        ax       = {fx_q, px_q[3:0]};
        ay       = {fy_q, py_q[3:0]};
        prm_addr = {fy_q, fx_q};
      end
      2'd1: begin
        px_max   = 6'd31;
        lcu_max  = 3'd3;
        ax       = {fx_q[1:0], px_q[4:0]};
        ay       = {fy_q[1:0], py_q[4:0]};
        prm_addr = {2'd0, fy_q[1:0], fx_q[1:0]};
      end
      default: ;
    endcase
  end

  assign px_last  = (px_q == px_max);
  assign py_last  = (py_q == px_max);
  assign fx_last  = (fx_q == lcu_max);
  assign fy_last  = (fy_q == lcu_max);
  assign empty    = !rd_vld_q && !skid_vld_q;

  assign img_addr = {ay, ax};
  assign img_rd   = (state_q == S_STREAM) && !busy && !skid_vld_q;
  assign prm_rd   = (state_q == S_PRM);

  // The skid always holds an older pixel than any returning word, so it wins.
  assign out_vld   = skid_vld_q || rd_vld_q;
  assign out_pix   = skid_vld_q ? skid_q : img_q;
  assign out_first = skid_vld_q ? skid_first_q : rd_first_q;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_PRM;
      S_PRM:    state_d = S_PRMW;
      S_PRMW:   state_d = S_STREAM;
      S_STREAM: if (img_rd && px_last && py_last)
                  state_d = (fx_last && fy_last) ? S_DRAIN : S_PRM;
      S_DRAIN:  if (empty) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      size_q       <= 2'd0;
      fx_q         <= 3'd0;
      fy_q         <= 3'd0;
      px_q         <= 6'd0;
      py_q         <= 6'd0;
      stg_prm_q    <= 24'd0;
      stg_x_q      <= 3'd0;
      stg_y_q      <= 3'd0;
      rd_vld_q     <= 1'b0;
      rd_first_q   <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_first_q <= 1'b0;
      skid_q       <= 8'd0;
      in_en_q      <= 1'b0;
      din_q        <= 8'd0;
      done_q       <= 1'b0;
      prm_out_q    <= 24'd0;
      lx_out_q     <= 3'd0;
      ly_out_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;

      if (state_q == S_IDLE && start) begin
        size_q <= (cfg_lcu_size == 2'd3) ? 2'd2 : cfg_lcu_size;
        fx_q   <= 3'd0;
        fy_q   <= 3'd0;
        px_q   <= 6'd0;
        py_q   <= 6'd0;
      end

      // Fetch counters still point at the LCU whose parameters arrive now.
      if (state_q == S_PRMW) begin
        stg_prm_q <= prm_q;
        stg_x_q   <= fx_q;
        stg_y_q   <= fy_q;
      end

      if (img_rd) begin
        if (!px_last) px_q <= px_q + 6'd1;
        else begin
          px_q <= 6'd0;
          if (!py_last) py_q <= py_q + 6'd1;
          else begin
            py_q <= 6'd0;
            if (!fx_last) fx_q <= fx_q + 3'd1;
            else begin
              fx_q <= 3'd0;
              fy_q <= fy_last ? 3'd0 : fy_q + 3'd1;
            end
          end
        end
      end

      rd_vld_q   <= img_rd;
      rd_first_q <= img_rd && (px_q == 6'd0) && (py_q == 6'd0);

      // A word returning under busy parks in the skid; reads are blocked while
      // it is full, so the skid and a returning word never collide.
      if (busy) begin
        if (rd_vld_q) begin
          skid_vld_q   <= 1'b1;
          skid_q       <= img_q;
          skid_first_q <= rd_first_q;
        end
      end else begin
        skid_vld_q <= 1'b0;
      end

      if (busy) begin
        in_en_q <= 1'b0;
      end else begin
        in_en_q <= out_vld;
        if (out_vld) din_q <= out_pix;
        if (out_vld && out_first) begin
          prm_out_q <= stg_prm_q;
          lx_out_q  <= stg_x_q;
          ly_out_q  <= stg_y_q;
        end
      end
    end
  end

  assign in_en        = in_en_q;
  assign din          = din_q;
  assign done         = done_q;
  assign lcu_size     = size_q;
  assign lcu_x        = lx_out_q;
  assign lcu_y        = ly_out_q;
  assign ipf_type     = prm_out_q[23:22];
  assign ipf_band_pos = prm_out_q[21:17];
  assign ipf_wo_class = prm_out_q[16];
  assign ipf_offset   = prm_out_q[15:0];

endmodule

// File: tb/tb_ipf_lcu_feeder.sv
// Directed bench for ipf_lcu_feeder with image/parameter ROM models and a
// capture monitor recording every delivered pixel and its side-band.
module tb_ipf_lcu_feeder;
  localparam int NPIX = 16384;

  logic        clk = 1'b0;
  logic        reset, start, busy;
  logic [1:0]  cfg;
  logic        img_rd, prm_rd, in_en, done, ipf_wo_class;
  logic [13:0] img_addr;
  logic [7:0]  img_q, din;
  logic [5:0]  prm_addr;
  logic [23:0] prm_q;
  logic [1:0]  ipf_type, lcu_size;
  logic [4:0]  ipf_band_pos;
  logic [15:0] ipf_offset;
  logic [2:0]  lcu_x, lcu_y;

  ipf_lcu_feeder dut (
    .clk(clk), .reset(reset), .start(start), .cfg_lcu_size(cfg),
    .img_rd(img_rd), .img_addr(img_addr), .img_q(img_q),
    .prm_rd(prm_rd), .prm_addr(prm_addr), .prm_q(prm_q),
    .busy(busy), .in_en(in_en), .din(din),
    .ipf_type(ipf_type), .ipf_band_pos(ipf_band_pos), .ipf_wo_class(ipf_wo_class),
    .ipf_offset(ipf_offset), .lcu_x(lcu_x), .lcu_y(lcu_y), .lcu_size(lcu_size),
    .done(done)
  );

  always #5 clk = ~clk;

  bit img_xor = 1'b0;

  function automatic logic [7:0] img_fn(input logic [13:0] a);
    return a[7:0] ^ (img_xor ? {1'b0, a[13:7]} : 8'h00);
  endfunction

  function automatic logic [23:0] prm_fn(input int i);
    int t;
    t = (i + 1) * 65793;   // 0x010101 per step
    return (i == 2) ? 24'hABCDEF : t[23:0];
  endfunction

  always_ff @(posedge clk) begin
    if (img_rd) img_q <= img_fn(img_addr);
    if (prm_rd) prm_q <= prm_fn(int'(prm_addr));
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // capture monitor
  logic [7:0]  cap_din [NPIX];
  logic [2:0]  cap_x   [NPIX];
  logic [2:0]  cap_y   [NPIX];
  logic [23:0] cap_par [NPIX];
  int          cap_cyc [NPIX];
  int cyc = 0, cap_n, done_n, viol, prm_cnt, first_prm, first_img;
  int first_en, last_en, done_cyc, start_cyc;
  bit started;

  task automatic clr();
    cap_n = 0; done_n = 0; viol = 0; prm_cnt = 0; first_prm = -1; first_img = -1;
    first_en = -1; last_en = 0; done_cyc = 0; start_cyc = 0; started = 0;
  endtask

  initial begin
    logic bs, ss, pr, ir;
    logic [5:0]  pa;
    logic [13:0] ia;
    forever begin
      @(posedge clk);
      bs = busy; ss = start; pr = prm_rd; pa = prm_addr; ir = img_rd; ia = img_addr;
      #1;
      cyc++;
      if (ss && !started) begin started = 1; start_cyc = cyc; end
      if (pr) begin prm_cnt++; if (first_prm < 0) first_prm = int'(pa); end
      if (ir && first_img < 0) first_img = int'(ia);
      if (in_en) begin
        if (cap_n < NPIX) begin
          cap_din[cap_n] = din;
          cap_x[cap_n]   = lcu_x;
          cap_y[cap_n]   = lcu_y;
          cap_par[cap_n] = {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset};
          cap_cyc[cap_n] = cyc;
        end
        cap_n++;
        last_en = cyc;
        if (first_en < 0) first_en = cyc;
        if (bs) viol++;
      end
      if (done) begin done_n++; done_cyc = cyc; end
    end
  end

  // Pulse start, then drive busy each cycle until done or maxc cycles elapse.
  task automatic run_frame(input logic [1:0] c, input bit rnd, input bit hold,
                           input bit mid, input int maxc);
    int hc = 0, n = 0, d0;
    bit fired = 0;
    d0 = done_n;
    @(negedge clk); cfg = c; start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (done_n == d0 && n < maxc) begin
      if (rnd) busy = 1'($urandom_range(0, 1));
      else if (hc > 0) begin busy = 1'b1; hc--; end
      else busy = 1'b0;
      // last pixel of LCU 0 at size 64 is {63,63}; stall its return
      if (hold && !fired && img_rd && img_addr == 14'h1FBF) begin hc = 10; fired = 1; end
      if (mid) begin
        start = (n == 50);
        if (n == 50) cfg = 2'd0;
      end
      @(negedge clk); n++;
    end
    busy = 1'b0; start = 1'b0;
  endtask

  // Expected stream derived arithmetically from the pixel index.
  task automatic chk_stream(input string tag, input int sz);
    int errs = 0, per, lcu, rem, px, py, lx, ly, a;
    per = 128 / sz;
    for (int k = 0; k < NPIX; k++) begin
      lcu = k / (sz * sz); rem = k % (sz * sz);
      py = rem / sz; px = rem % sz;
      lx = lcu % per; ly = lcu / per;
      a = (ly * sz + py) * 128 + lx * sz + px;
      if (cap_din[k] !== img_fn(a[13:0]) || cap_x[k] !== lx[2:0] ||
          cap_y[k] !== ly[2:0] || cap_par[k] !== prm_fn(ly * per + lx))
        errs++;
    end
    chk(tag, errs, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; busy = 1'b0; cfg = 2'd0;
    clr();
    repeat (3) @(negedge clk);
    chk("rst_in_en", in_en, 0);
    chk("rst_din", din, 0);
    chk("rst_rd", {img_rd, prm_rd, done}, 0);
    chk("rst_addr", {img_addr, prm_addr}, 0);
    chk("rst_side", {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset, lcu_x, lcu_y, lcu_size}, 0);
    reset = 1'b0;

    // size 16, no stall, img = addr[7:0]
    clr(); img_xor = 1'b0;
    run_frame(2'd0, 0, 0, 0, 30000);
    chk("s16_count", cap_n, NPIX);
    chk("s16_done", done_n, 1);
    chk("s16_latency", first_en - start_cyc, 4);
    chk("s16_done_pos", done_cyc - last_en, 1);
    chk("s16_prm_reads", prm_cnt, 64);
    chk("s16_din0", cap_din[0], 8'h00);
    chk("s16_din15", cap_din[15], 8'h0F);
    chk("s16_row1", cap_din[16], 8'h80);
    chk("s16_row1_end", cap_din[31], 8'h8F);
    chk("s16_lcu1_din", cap_din[256], 8'h10);
    chk("s16_lcu1_x", cap_x[256], 1);
    chk("s16_lcu0_x", cap_x[255], 0);
    chk("s16_bubble", cap_cyc[256] - cap_cyc[255], 3);
    chk("s16_size", lcu_size, 0);
    chk_stream("s16_stream", 16);

    // reserved size 3 -> 64, ignored mid-frame start, 10-cycle stall on LCU 0 tail
    clr(); img_xor = 1'b1;
    run_frame(2'd3, 0, 1, 1, 30000);
    chk("s64_count", cap_n, NPIX);
    chk("s64_done", done_n, 1);
    chk("s64_prm_reads", prm_cnt, 4);
    chk("s64_size", lcu_size, 2);
    chk("s64_par_lcu2", cap_par[8192], 24'hABCDEF);
    chk("s64_par_before", cap_par[8191], 24'h020202);
    chk("s64_xy_lcu2", {cap_x[8192], cap_y[8192]}, {3'd0, 3'd1});
    chk("s64_din_lcu2", cap_din[8192], 8'h40);
    chk("hold_gap", cap_cyc[4095] - cap_cyc[4094], 11);
    chk("hold_par_last", cap_par[4095], 24'h010101);
    chk("hold_par_next", cap_par[4096], 24'h020202);
    chk("hold_x_next", cap_x[4096], 1);
    chk("hold_viol", viol, 0);
    chk("s64_end_side", {ipf_offset, lcu_x, lcu_y}, {16'h0404, 3'd1, 3'd1});
    chk_stream("s64_stream", 64);

    // size 32 with random 50% busy
    clr();
    run_frame(2'd1, 1, 0, 0, 60000);
    chk("rnd_count", cap_n, NPIX);
    chk("rnd_done", done_n, 1);
    chk("rnd_viol", viol, 0);
    chk("rnd_prm_reads", prm_cnt, 16);
    chk("rnd_done_pos", done_cyc - last_en, 1);
    chk_stream("rnd_stream", 32);

    // reset 100 cycles into a frame, then restart
    clr();
    run_frame(2'd1, 0, 0, 0, 100);
    reset = 1'b1;
    #1;
    chk("abort_in_en", in_en, 0);
    chk("abort_din", din, 0);
    chk("abort_rd", {img_rd, prm_rd, done}, 0);
    chk("abort_addr", {img_addr, prm_addr}, 0);
    chk("abort_side", {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset, lcu_x, lcu_y, lcu_size}, 0);
    chk("abort_no_done", done_n, 0);
    @(negedge clk); reset = 1'b0;
    clr();
    run_frame(2'd0, 0, 0, 0, 20);
    chk("restart_img", first_img, 0);
    chk("restart_prm", first_prm, 0);
    chk("restart_latency", first_en - start_cyc, 4);
    chk("restart_din0", cap_din[0], 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
